// File: rtl/pwr_toggle_counter_pkg.sv
// pwr_mon_pkg: shared defaults, width derivation and saturating add for the toggle counter.
package pwr_mon_pkg;
    localparam int NCH_DEF = 8;
    localparam int CW_DEF = 16;

    function automatic int selw_of(int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int tw_of(int nch, int cw);
        return cw + selw_of(nch);
    endfunction

    function automatic logic [63:0] sat_add(logic [63:0] a, logic [63:0] inc, int w);
        logic [63:0] max;
        max = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
        return (a >= max || inc > max - a) ? max : a + inc;
    endfunction
endpackage

// File: rtl/pwr_toggle_counter_if.sv
// pwr_toggle_counter_if: monitored nets, control and readout bundle of the toggle counter.
interface pwr_toggle_counter_if import pwr_mon_pkg::*; #(
    parameter int NCH = NCH_DEF,
    parameter int CW = CW_DEF
);
    localparam int SELW = selw_of(NCH);
    localparam int TW = tw_of(NCH, CW);
    logic [NCH-1:0] sig;
    logic clr;
    logic freeze;
    logic rd_en;
    logic [SELW-1:0] sel;
    logic [CW-1:0] rd_data;
    logic rd_valid;
    logic [TW-1:0] total;
    logic [NCH-1:0] ovf;
    modport master (output sig, clr, freeze, rd_en, sel, input rd_data, rd_valid, total, ovf);
    modport slave (input sig, clr, freeze, rd_en, sel, output rd_data, rd_valid, total, ovf);
endinterface

// File: rtl/pwr_toggle_counter_chan_cnt.sv
// pwr_chan_cnt: one channel's edge detector, rising-edge counter and sticky overflow.
// PWR_CNT_WRAP_EN selects wrapping counters with overflow flag; otherwise saturating.
module pwr_chan_cnt import pwr_mon_pkg::*; #(
    parameter int CW = CW_DEF
) (
    input  logic          C,
    input  logic          R,
    input  logic          armed,
    input  logic          clr,
    input  logic          freeze,
    input  logic          sig,
    output logic          rise,
    output logic [CW-1:0] cnt,
    output logic          ovf
);
    logic prev;
    logic wrap;
    logic [CW-1:0] cnt_nx;
    assign rise = armed & sig & ~prev;
`ifdef PWR_CNT_WRAP_EN
    assign cnt_nx = cnt + CW'(1);
    assign wrap = &cnt;
`else
    assign cnt_nx = CW'(sat_add(64'(cnt), 64'd1, CW));
    assign wrap = 1'b0;
`endif
    always_ff @(posedge C) begin
        if (R) begin
            prev <= 1'b0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            prev <= sig;
            if (clr) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (!freeze && rise) begin
                cnt <= cnt_nx;
                ovf <= ovf | wrap;
            end
        end
    end
endmodule

// File: rtl/pwr_toggle_counter.sv
// pwr_toggle_counter: NCH-channel rising-transition counter with running total and readout.
// PWR_CNT_WRAP_EN selects wrapping counters/total with sticky overflow; otherwise saturating.
module pwr_toggle_counter import pwr_mon_pkg::*; #(
    parameter int NCH = NCH_DEF,
    parameter int CW = CW_DEF
) (
    input logic C,
    input logic R,
    pwr_toggle_counter_if.slave bus
);
    localparam int SELW = selw_of(NCH);
    localparam int TW = tw_of(NCH, CW);
    logic armed;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] ovf;
    logic [CW-1:0] cnt [NCH];
    logic [CW-1:0] pad [2**SELW];
    logic [TW-1:0] pc;
    logic [TW-1:0] total;
    logic [TW-1:0] total_nx;
    logic [CW-1:0] rd_data;
    logic rd_valid;
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwr_chan_cnt #(.CW(CW)) u_ch (
            .C(C),
            .R(R),
            .armed(armed),
            .clr(bus.clr),
            .freeze(bus.freeze),
            .sig(bus.sig[i]),
            .rise(rise[i]),
            .cnt(cnt[i]),
            .ovf(ovf[i])
        );
    end
    // Unused select codes read as zero.
    for (genvar i = 0; i < 2**SELW; i++) begin : g_pad
        if (i < NCH) begin : g_on
            assign pad[i] = cnt[i];
        end else begin : g_off
            assign pad[i] = '0;
        end
    end
    always_comb begin
        pc = '0;
        for (int i = 0; i < NCH; i++) pc = pc + TW'(rise[i]);
    end
`ifdef PWR_CNT_WRAP_EN
    assign total_nx = total + pc;
`else
    assign total_nx = TW'(sat_add(64'(total), 64'(pc), TW));
`endif
    always_ff @(posedge C) begin
        if (R) begin
            armed <= 1'b0;
            total <= '0;
            rd_data <= '0;
            rd_valid <= 1'b0;
        end else begin
            armed <= 1'b1;
            total <= bus.clr ? '0 : bus.freeze ? total : total_nx;
            rd_valid <= bus.rd_en;
            if (bus.rd_en) rd_data <= pad[bus.sel];
        end
    end
    assign bus.total = total;
    assign bus.rd_data = rd_data;
    assign bus.rd_valid = rd_valid;
    assign bus.ovf = ovf;
endmodule

// File: tb/tb_pwr_toggle_counter.sv
// tb_pwr_toggle_counter: scoreboard bench for the toggle counter, default and CW=2 instances.
module tb_pwr_toggle_counter;
    logic C = 1'b0;
    logic R;
    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];
    int mcnt[8];
    int mtot;
    logic [7:0] mprev;
    logic marmed;
    logic exp_valid;

    pwr_toggle_counter_if #(.NCH(8), .CW(16)) di ();
    pwr_toggle_counter_if #(.NCH(8), .CW(2)) si ();

    pwr_toggle_counter #(.NCH(8), .CW(16)) dut (.C(C), .R(R), .bus(di));
    pwr_toggle_counter #(.NCH(8), .CW(2)) dut_s (.C(C), .R(R), .bus(si));

    always #5 C = ~C;

    // Advances the reference model with the currently driven inputs, clocks, then checks.
    task automatic tick();
        int old[8];
        int n;
        if (R) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            mtot = 0;
            mprev = '0;
            marmed = 1'b0;
            exp_q.delete();
        end else begin
            foreach (mcnt[i]) old[i] = mcnt[i];
            if (di.rd_en) exp_q.push_back(old[di.sel]);
            n = 0;
            for (int i = 0; i < 8; i++)
                if (marmed && di.sig[i] && !mprev[i] && !di.clr && !di.freeze) begin
                    mcnt[i]++;
                    n++;
                end
            if (di.clr) begin
                foreach (mcnt[i]) mcnt[i] = 0;
                mtot = 0;
            end else if (!di.freeze) mtot += n;
            mprev = di.sig;
            marmed = 1'b1;
        end
        exp_valid = !R && di.rd_en;
        @(posedge C);
        #1;
        n_chk++;
        if (di.total !== 19'(mtot)) begin
            n_fail++;
            $display("FAIL total: got %0d expected %0d", di.total, mtot);
        end
        n_chk++;
        if (di.rd_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL rd_valid: got %b expected %b", di.rd_valid, exp_valid);
        end
        n_chk++;
        if (di.ovf !== 8'h00) begin
            n_fail++;
            $display("FAIL ovf_main: got %h expected 00", di.ovf);
        end
        if (di.rd_valid === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got data %0d with no read pending", di.rd_data);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (di.rd_data !== 16'(e)) begin
                    n_fail++;
                    $display("FAIL rd_data: got %0d expected %0d", di.rd_data, e);
                end
            end
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) begin
            di.rd_en = 1'b1;
            di.sel = 3'(i);
            tick();
        end
        di.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        R = 1'b1;
        di.sig = 8'hFF;
        repeat (3) tick();
        n_chk++;
        if (di.total !== '0 || di.rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got total %0d rd_data %0d expected 0 0", di.total, di.rd_data);
        end
        R = 1'b0;
        repeat (2) tick();
        read_all();
        n_chk++;
        if (di.total !== '0) begin
            n_fail++;
            $display("FAIL arm_no_count: got total %0d expected 0", di.total);
        end
    endtask

    task automatic test_toggle();
        di.sig = 8'h00;
        tick();
        repeat (5) begin
            di.sig[0] = 1'b1;
            tick();
            di.sig[0] = 1'b0;
            tick();
        end
        di.rd_en = 1'b1;
        di.sel = 3'd0;
        tick();
        di.rd_en = 1'b0;
        n_chk++;
        if (di.rd_data !== 16'd5 || di.total !== 19'd5) begin
            n_fail++;
            $display("FAIL toggle5: got rd_data %0d total %0d expected 5 5", di.rd_data, di.total);
        end
        tick();
    endtask

    task automatic test_all_rise();
        di.sig = 8'h00;
        tick();
        di.sig = 8'hFF;
        tick();
        n_chk++;
        if (di.total !== 19'd13) begin
            n_fail++;
            $display("FAIL all_rise_total: got %0d expected 13", di.total);
        end
        di.rd_en = 1'b1;
        di.sel = 3'd7;
        tick();
        di.rd_en = 1'b0;
        n_chk++;
        if (di.rd_data !== 16'd1) begin
            n_fail++;
            $display("FAIL all_rise_ch7: got %0d expected 1", di.rd_data);
        end
        read_all();
    endtask

    task automatic test_sat();
        logic [1:0] e_data;
        logic [7:0] e_ovf;
`ifdef PWR_CNT_WRAP_EN
        e_data = 2'd1;
        e_ovf = 8'h04;
`else
        e_data = 2'd3;
        e_ovf = 8'h00;
`endif
        si.clr = 1'b1;
        tick();
        si.clr = 1'b0;
        repeat (5) begin
            si.sig[2] = 1'b1;
            tick();
            si.sig[2] = 1'b0;
            tick();
        end
        si.rd_en = 1'b1;
        si.sel = 3'd2;
        tick();
        si.rd_en = 1'b0;
        n_chk++;
        if (si.rd_valid !== 1'b1 || si.rd_data !== e_data) begin
            n_fail++;
            $display("FAIL cw2_read: got valid %b data %0d expected 1 %0d", si.rd_valid, si.rd_data, e_data);
        end
        n_chk++;
        if (si.ovf !== e_ovf || si.total !== 5'd5) begin
            n_fail++;
            $display("FAIL cw2_ovf_total: got ovf %h total %0d expected %h 5", si.ovf, si.total, e_ovf);
        end
        tick();
        n_chk++;
        if (si.ovf !== e_ovf) begin
            n_fail++;
            $display("FAIL cw2_ovf_sticky: got %h expected %h", si.ovf, e_ovf);
        end
        si.clr = 1'b1;
        tick();
        si.clr = 1'b0;
        n_chk++;
        if (si.ovf !== 8'h00 || si.total !== 5'd0) begin
            n_fail++;
            $display("FAIL cw2_clr: got ovf %h total %0d expected 00 0", si.ovf, si.total);
        end
    endtask

    task automatic test_clr_freeze();
        di.sig = 8'h00;
        tick();
        di.sig[1] = 1'b1;
        di.clr = 1'b1;
        tick();
        di.clr = 1'b0;
        n_chk++;
        if (di.total !== 19'd0) begin
            n_fail++;
            $display("FAIL clr_edge_total: got %0d expected 0", di.total);
        end
        di.freeze = 1'b1;
        repeat (3) begin
            di.sig[3] = 1'b1;
            tick();
            di.sig[3] = 1'b0;
            tick();
        end
        n_chk++;
        if (di.total !== 19'd0) begin
            n_fail++;
            $display("FAIL freeze_total: got %0d expected 0", di.total);
        end
        di.freeze = 1'b0;
        di.sig[3] = 1'b1;
        tick();
        n_chk++;
        if (di.total !== 19'd1) begin
            n_fail++;
            $display("FAIL unfreeze_total: got %0d expected 1", di.total);
        end
        read_all();
    endtask

    task automatic test_read_race();
        di.sig[3] = 1'b0;
        tick();
        di.sig[3] = 1'b1;
        di.rd_en = 1'b1;
        di.sel = 3'd3;
        tick();
        n_chk++;
        if (di.rd_data !== 16'd1) begin
            n_fail++;
            $display("FAIL race_old_value: got %0d expected 1", di.rd_data);
        end
        tick();
        n_chk++;
        if (di.rd_data !== 16'd2) begin
            n_fail++;
            $display("FAIL race_new_value: got %0d expected 2", di.rd_data);
        end
        R = 1'b1;
        tick();
        di.rd_en = 1'b0;
        n_chk++;
        if (di.rd_valid !== 1'b0 || di.rd_data !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_read: got valid %b data %0d expected 0 0", di.rd_valid, di.rd_data);
        end
        R = 1'b0;
        tick();
    endtask

    initial begin
        R = 1'b1;
        di.sig = '0;
        di.clr = 1'b0;
        di.freeze = 1'b0;
        di.rd_en = 1'b0;
        di.sel = '0;
        si.sig = '0;
        si.clr = 1'b0;
        si.freeze = 1'b0;
        si.rd_en = 1'b0;
        si.sel = '0;
        test_reset();
        test_toggle();
        test_all_rise();
        test_sat();
        test_clr_freeze();
        test_read_race();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
